// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: owns the PC, issues valid/ready fetch requests and applies redirects.
// Optional misaligned-redirect trap is enabled by defining PC_TRAP_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
`ifdef PC_TRAP_EN
  ,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        redirect_pending
`ifdef PC_TRAP_EN
  ,
  output logic        misalign_trap
`endif
);

  typedef enum logic [1:0] {
    StBoot,
    StReq,
    StHold
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        pend_trap_q, pend_trap_d;
  logic        trap_q, trap_d;
  logic        req_valid_q;

  logic [31:0] redir_tgt;
  logic        redir_trap;
  logic        accept;

  // Redirect targets are resolved once, before they reach either the pc or the pending slot.
`ifdef PC_TRAP_EN
  assign redir_trap = |redirect_target[1:0];
  assign redir_tgt  = redir_trap ? TRAP_VECTOR : redirect_target;
`else
  logic unused_trap;
  assign redir_trap  = 1'b0;
  assign redir_tgt   = {redirect_target[31:2], 2'b00};
  assign unused_trap = ^{trap_q, redirect_target[1:0]};
`endif

  assign pc_plus4 = pc_q + 32'd4;
  assign accept   = req_valid_q & imem_req_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_tgt_d  = pend_tgt_q;
    pend_trap_d = pend_trap_q;
    trap_d      = 1'b0;
    unique case (state_q)
      StBoot, StHold: begin
        // No request in flight, so a redirect lands on the pc directly.
        if (redirect_valid) begin
          pc_d   = redir_tgt;
          trap_d = redir_trap;
        end
        pend_d      = 1'b0;
        pend_trap_d = 1'b0;
        state_d     = (state_q == StBoot || !stall) ? StReq : StHold;
      end
      StReq: begin
        if (accept) begin
          if (redirect_valid) begin
            pc_d   = redir_tgt;
            trap_d = redir_trap;
          end else if (pend_q) begin
            pc_d   = pend_tgt_q;
            trap_d = pend_trap_q;
          end else begin
            pc_d = pc_plus4;
          end
          pend_d      = 1'b0;
          pend_trap_d = 1'b0;
          state_d     = stall ? StHold : StReq;
        end else if (redirect_valid) begin
          // Address must stay stable while waiting; park the redirect until the accept.
          pend_d      = 1'b1;
          pend_tgt_d  = redir_tgt;
          pend_trap_d = redir_trap;
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StBoot;
      pc_q        <= RESET_VECTOR;
      pend_q      <= 1'b0;
      pend_tgt_q  <= 32'h0;
      pend_trap_q <= 1'b0;
      trap_q      <= 1'b0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_trap_q <= pend_trap_d;
      trap_q      <= trap_d;
      req_valid_q <= (state_d == StReq);
    end
  end

  assign imem_req_valid   = req_valid_q;
  assign imem_req_addr    = pc_q;
  assign pc               = pc_q;
  assign redirect_pending = pend_q;
`ifdef PC_TRAP_EN
  assign misalign_trap    = trap_q;
`endif

  // A presented request is never withdrawn or altered before it is accepted.
  property p_req_stable;
    @(posedge clk) disable iff (rst)
      (imem_req_valid && !imem_req_ready) |=> (imem_req_valid && $stable(imem_req_addr));
  endproperty
  a_req_stable: assert property (p_req_stable);

  property p_pend_only_in_req;
    @(posedge clk) disable iff (rst) redirect_pending |-> imem_req_valid;
  endproperty
  a_pend_only_in_req: assert property (p_pend_only_in_req);

endmodule
